// File: rtl/prince_nibble_share_feeder.sv
// Two-share nibble serialiser feeding the masked PRINCE S-box register row.
// Loads a 64-bit two-share state, then emits it low nibble first. Each nibble's
// shares are refreshed with a fresh rnd sample on the loading/advancing edge.
// All data outputs come straight from flops, so no output path depends
// combinationally on rnd.
//
// state | meaning
// IDLE  | ready for a new state; in_ready=1, outputs hold last values
// SHIFT | presenting one refreshed nibble per transfer; out_valid=1
module prince_nibble_share_feeder #(
  parameter int NIBBLES = 16,
  parameter int IDX_W   = 4
) (
  input  logic                   CK,
  input  logic                   RN,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_s0,
  input  logic [4*NIBBLES-1:0]   in_s1,
  input  logic [3:0]             rnd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_s0,
  output logic [3:0]             out_s1,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   done
);

  localparam int SW = 4 * NIBBLES;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       out_s0_q, out_s0_d;
  logic [3:0]       out_s1_q, out_s1_d;
  logic [IDX_W-1:0] out_idx_q, out_idx_d;
  logic [SW-5:0]    r0_q, r0_d;
  logic [SW-5:0]    r1_q, r1_d;
  logic             done_q, done_d;

  // State and datapath registers; reset clears every share-carrying flop.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= IDLE;
      out_s0_q  <= '0;
      out_s1_q  <= '0;
      out_idx_q <= '0;
      r0_q      <= '0;
      r1_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_s0_q  <= out_s0_d;
      out_s1_q  <= out_s1_d;
      out_idx_q <= out_idx_d;
      r0_q      <= r0_d;
      r1_q      <= r1_d;
      done_q    <= done_d;
    end
  end

  // Next-state and datapath: shares are only ever XORed with rnd, never with
  // each other, and rnd is consumed only on a load or an advancing transfer.
  always_comb begin
    state_d   = state_q;
    out_s0_d  = out_s0_q;
    out_s1_d  = out_s1_q;
    out_idx_d = out_idx_q;
    r0_d      = r0_q;
    r1_d      = r1_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          out_s0_d  = in_s0[3:0] ^ rnd;
          out_s1_d  = in_s1[3:0] ^ rnd;
          r0_d      = in_s0[SW-1:4];
          r1_d      = in_s1[SW-1:4];
          out_idx_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          if (out_idx_q == LAST_IDX) begin
            // Final nibble consumed; data flops keep their values, out_valid masks them.
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            out_s0_d  = r0_q[3:0] ^ rnd;
            out_s1_d  = r1_q[3:0] ^ rnd;
            r0_d      = r0_q >> 4;
            r1_d      = r1_q >> 4;
            out_idx_d = out_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid && (out_idx_q == LAST_IDX);
  assign out_s0    = out_s0_q;
  assign out_s1    = out_s1_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_prince_nibble_share_feeder.sv
// Scoreboard bench for prince_nibble_share_feeder: the expected nibble for each
// load/advance edge is pushed when stimulus is driven and compared when shown.
module tb_prince_nibble_share_feeder;

  localparam int N  = 16;
  localparam int IW = 4;

  logic          CK = 1'b0;
  logic          RN = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_s0 = '0;
  logic [63:0]   in_s1 = '0;
  logic [3:0]    rnd = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [3:0]    out_s0;
  logic [3:0]    out_s1;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;

  prince_nibble_share_feeder #(.NIBBLES(N), .IDX_W(IW)) dut (
    .CK(CK), .RN(RN),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s0(in_s0), .in_s1(in_s1), .rnd(rnd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s0(out_s0), .out_s1(out_s1), .out_idx(out_idx),
    .out_last(out_last), .done(done)
  );

  always #5 CK = ~CK;

  typedef struct packed {
    logic [3:0] s0;
    logic [3:0] s1;
    logic [3:0] idx;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  bit          m_shift = 0;
  int          m_idx = 0;
  logic [63:0] m_s0 = '0;
  logic [63:0] m_s1 = '0;
  bit          m_done = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          n_loads = 0;
  int          n_dones = 0;
  int          first_load_cyc = 0;
  int          last_done_cyc = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push_exp(input logic [3:0] r);
    exp_t e;
    e.s0  = m_s0[4*m_idx +: 4] ^ r;
    e.s1  = m_s1[4*m_idx +: 4] ^ r;
    e.idx = 4'(m_idx);
    sb_q.push_back(e);
  endtask

  // One clock: drive inputs, update the reference model for the coming edge,
  // then sample the DUT 1 time unit after the edge and compare.
  task automatic cycle(input logic iv, input logic [63:0] s0, input logic [63:0] s1,
                       input logic [3:0] r, input logic ordy);
    logic [63:0] xs;
    in_valid  = iv;
    in_s0     = s0;
    in_s1     = s1;
    rnd       = r;
    out_ready = ordy;
    m_done    = 0;
    if (RN) begin
      if (!m_shift) begin
        if (iv) begin
          m_s0 = s0;
          m_s1 = s1;
          m_idx = 0;
          push_exp(r);
          m_shift = 1;
          n_loads++;
          if (n_loads == 1) first_load_cyc = cyc + 1;
        end
      end else if (ordy) begin
        if (sb_q.size() > 0) void'(sb_q.pop_front());
        if (m_idx < N - 1) begin
          m_idx++;
          push_exp(r);
        end else begin
          m_shift = 0;
          m_done  = 1;
        end
      end
    end
    @(posedge CK);
    #1;
    cyc++;
    if (done) begin
      done_cnt++;
      n_dones++;
      last_done_cyc = cyc;
    end
    chk("in_ready", in_ready, !m_shift);
    chk("out_valid", out_valid, m_shift);
    chk("done", done, m_done);
    if (m_shift) begin
      if (sb_q.size() != 1) chk("sb_depth", sb_q.size(), 1);
      else begin
        chk("out_s0", out_s0, sb_q[0].s0);
        chk("out_s1", out_s1, sb_q[0].s1);
        chk("out_idx", out_idx, sb_q[0].idx);
        chk("out_last", out_last, sb_q[0].idx == 4'(N - 1));
        xs = m_s0 ^ m_s1;
        chk("invariant", out_s0 ^ out_s1, xs[4*m_idx +: 4]);
      end
    end else begin
      chk("out_last_idle", out_last, 0);
    end
  endtask

  logic [63:0] a_s0, a_s1, b_s0, b_s1;
  bit          got;

  initial begin
    // Reset and idle
    RN = 1'b0;
    repeat (2) @(posedge CK);
    #1;
    RN = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_out_s0", out_s0, 0);
    chk("rst_out_s1", out_s1, 0);
    chk("rst_out_idx", out_idx, 0);
    cycle(0, '1, '1, 4'hF, 1);
    cycle(0, '1, '1, 4'hF, 1);

    // Single load, plain data, rnd 0
    done_cnt = 0;
    got = 0;
    cycle(1, 64'h0123456789ABCDEF, 64'h0, 4'h0, 1);
    for (int k = 0; k < 40 && !got; k++) begin
      cycle(0, '0, '0, 4'h0, 1);
      got = m_done;
    end
    chk("single_timeout", got, 1);
    cycle(0, '0, '0, 4'h0, 1);
    cycle(0, '0, '0, 4'h0, 1);
    chk("single_done_cnt", done_cnt, 1);

    // Refresh: all-ones shares, rnd 5 -> both shares A, XOR 0
    got = 0;
    cycle(1, '1, '1, 4'h5, 1);
    chk("refresh_s0", out_s0, 4'hA);
    chk("refresh_s1", out_s1, 4'hA);
    for (int k = 0; k < 40 && !got; k++) begin
      cycle(0, '0, '0, 4'h5, 1);
      got = m_done;
    end
    chk("refresh_timeout", got, 1);
    cycle(0, '0, '0, 4'h0, 1);

    // Backpressure 1,0,0,1 with rnd changing every cycle
    got = 0;
    a_s0 = {$urandom, $urandom};
    a_s1 = {$urandom, $urandom};
    cycle(1, a_s0, a_s1, 4'($urandom), 1);
    for (int k = 0; k < 120 && !got; k++) begin
      cycle(0, '0, '0, 4'($urandom), ((k % 4) == 0) || ((k % 4) == 3));
      got = m_done;
    end
    chk("bp_timeout", got, 1);
    cycle(0, '0, '0, 4'h0, 1);

    // Back-to-back: in_valid held high with two different states
    a_s0 = 64'hFEDCBA9876543210;
    a_s1 = {$urandom, $urandom};
    b_s0 = 64'h1122334455667788;
    b_s1 = {$urandom, $urandom};
    n_loads = 0;
    n_dones = 0;
    for (int k = 0; k < 80 && n_dones < 2; k++) begin
      if (n_loads == 0) cycle(1, a_s0, a_s1, 4'($urandom), 1);
      else cycle(1, b_s0, b_s1, 4'($urandom), 1);
    end
    chk("b2b_dones", n_dones, 2);
    chk("b2b_loads", n_loads, 2);
    chk("b2b_cycles", last_done_cyc - first_load_cyc + 1, 34);
    cycle(0, '0, '0, 4'h0, 1);

    // Reset mid-stream at out_idx 7
    done_cnt = 0;
    cycle(1, {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom), 1);
    for (int k = 0; k < 20 && m_idx != 7; k++) cycle(0, '0, '0, 4'($urandom), 1);
    chk("mid_idx7", out_idx, 7);
    RN = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_in_ready", in_ready, 1);
    chk("mid_done", done, 0);
    chk("mid_out_s0", out_s0, 0);
    chk("mid_out_s1", out_s1, 0);
    chk("mid_out_idx", out_idx, 0);
    m_shift = 0;
    sb_q.delete();
    @(posedge CK);
    #2;
    RN = 1'b1;
    cycle(0, '0, '0, 4'h0, 1);
    chk("mid_no_done", done_cnt, 0);
    got = 0;
    cycle(1, 64'hA5A5_5A5A_0F0F_F0F0, 64'h3C3C_C3C3_9696_6969, 4'h9, 1);
    chk("restart_idx", out_idx, 0);
    for (int k = 0; k < 40 && !got; k++) begin
      cycle(0, '0, '0, 4'($urandom), 1);
      got = m_done;
    end
    chk("restart_timeout", got, 1);
    cycle(0, '0, '0, 4'h0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
